cycle_sequencer: RTL and testbench

Generates the eight-phase machine cycle (A1 A2 A3 M1 M2 X1 X2 X3) that paces the 4-bit CPU core inside `wb_system`, and owns run/halt/single-step control of that core. It sits between the debug controls (logic-analyzer halt, step request) and the CPU datapath. It tells the datapath when to drive address nibbles, when to capture the two instruction nibbles from the 4-bit ROM input pins, and when an instruction cycle completes. Halts take effect only on instruction-cycle boundaries, so the core is never frozen mid-instruction.

---
 rtl/cycle_sequencer_pkg.sv | 40 ++++
 rtl/cycle_sequencer_counter.sv | 33 +++
 rtl/cycle_sequencer.sv | 159 +++++++++++++++
 tb/tb_cycle_sequencer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/cycle_sequencer_pkg.sv
// cycle_sequencer_pkg
// Shared definitions for the machine-cycle sequencer: phase indices,
// sequencer state encoding and small decode helpers used by the top level.
package cycle_sequencer_pkg;

  // Sequencer control state
  typedef enum logic {
    HALTED = 1'b0,
    RUN    = 1'b1
  } state_e;

  // Phase indices within one machine cycle
  localparam logic [2:0] PH_A1 = 3'd0;
  localparam logic [2:0] PH_A2 = 3'd1;
  localparam logic [2:0] PH_A3 = 3'd2;
  localparam logic [2:0] PH_M1 = 3'd3;
  localparam logic [2:0] PH_M2 = 3'd4;
  localparam logic [2:0] PH_X1 = 3'd5;
  localparam logic [2:0] PH_X2 = 3'd6;
  localparam logic [2:0] PH_X3 = 3'd7;

  localparam int PHASES_PER_CYCLE = 8;

  // One-hot decode of a phase index (bit 0 = A1 ... bit 7 = X3)
  function automatic logic [7:0] phase_onehot(input logic [2:0] ph);
    return 8'b0000_0001 << ph;
  endfunction

  // ROM nibble capture strobes: bit 1 in M1 (high nibble), bit 0 in M2 (low nibble)
  function automatic logic [1:0] rom_latch_decode(input logic [2:0] ph);
    logic [1:0] strobe;
    case (ph)
      PH_M1:   strobe = 2'b10;
      PH_M2:   strobe = 2'b01;
      default: strobe = 2'b00;
    endcase
    return strobe;
  endfunction

endpackage

// File: rtl/cycle_sequencer_counter.sv
// cycle_counter
// Free-running wrap-around counter of completed machine cycles.
// Only instantiated when CYCLE_SEQUENCER_COUNT_EN is defined.
// Ports:
//   clock  - system clock (rising edge)
//   reset  - synchronous, active-high; clears the count
//   inc    - one-clock pulse per completed machine cycle
//   count  - completed cycle count, wraps from all-ones to zero
module cycle_counter #(
  parameter int COUNT_W = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               inc,
  output logic [COUNT_W-1:0] count
);

  logic [COUNT_W-1:0] count_r;

  // Count register; natural binary wrap on overflow
  always_ff @(posedge clock) begin
    if (reset) begin
      count_r <= '0;
    end else if (inc) begin
      count_r <= count_r + {{(COUNT_W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/cycle_sequencer.sv
// cycle_sequencer
// Produces the eight-phase machine cycle (A1 A2 A3 M1 M2 X1 X2 X3) for the
// 4-bit CPU core and owns its run / halt / single-step control. Halts only
// take effect at the end of X3 so an instruction is never frozen midway.
// All outputs are registered; no input reaches an output combinationally.
//
// Configuration: define CYCLE_SEQUENCER_COUNT_EN to build the completed-cycle
// counter; when undefined no counter flops exist and cycle_count is 0.
//
// Ports:
//   clock       - system clock (rising edge)
//   reset       - synchronous, active-high
//   halt_req    - level; requests a halt at the next cycle boundary
//   step_req    - level; each rising edge while halted runs one machine cycle
//   phase       - one-hot current phase, all-zero while halted
//   sync        - high during X3
//   rom_latch   - [1] capture high opcode nibble (M1), [0] low nibble (M2)
//   running     - phases are advancing
//   halted      - parked in HALTED
//   cycle_count - completed machine cycles (COUNT_W bits, wraps)
module cycle_sequencer
  import cycle_sequencer_pkg::*;
#(
  parameter int COUNT_W = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               halt_req,
  input  logic               step_req,
  output logic [7:0]         phase,
  output logic               sync,
  output logic [1:0]         rom_latch,
  output logic               running,
  output logic               halted,
  output logic [COUNT_W-1:0] cycle_count
);

  state_e     state_r;
  logic [2:0] ph_r;
  logic       step_active_r;
  logic       step_hist_r;

  state_e     state_next_s;
  logic [2:0] ph_next_s;
  logic       step_active_next_s;
  logic       step_edge_s;

  logic [7:0] phase_r;
  logic       sync_r;
  logic [1:0] rom_latch_r;
  logic       running_r;
  logic       halted_r;

  // Next-state decode for run/halt/step sequencing
  always_comb begin
    state_next_s       = state_r;
    ph_next_s          = ph_r;
    step_active_next_s = step_active_r;
    // History resets to 1 so a step_req held through reset is not an edge
    step_edge_s        = step_req & ~step_hist_r;

    case (state_r)
      HALTED: begin
        // A released halt wins over a simultaneous step edge
        if (!halt_req) begin
          state_next_s       = RUN;
          ph_next_s          = PH_A1;
          step_active_next_s = 1'b0;
        end else if (step_edge_s) begin
          state_next_s       = RUN;
          ph_next_s          = PH_A1;
          step_active_next_s = 1'b1;
        end else begin
          state_next_s       = HALTED;
          ph_next_s          = PH_A1;
          step_active_next_s = 1'b0;
        end
      end
      RUN: begin
        if (ph_r != PH_X3) begin
          ph_next_s = ph_r + 3'd1;
        end else begin
          // Cycle boundary: the only point in RUN where halt_req is honoured
          ph_next_s          = PH_A1;
          step_active_next_s = 1'b0;
          if (halt_req || step_active_r) begin
            state_next_s = HALTED;
          end else begin
            state_next_s = RUN;
          end
        end
      end
      default: begin
        state_next_s       = HALTED;
        ph_next_s          = PH_A1;
        step_active_next_s = 1'b0;
      end
    endcase
  end

  // Sequencer state and Moore outputs, decoded from the next state so they
  // line up with the state they describe
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r       <= HALTED;
      ph_r          <= PH_A1;
      step_active_r <= 1'b0;
      step_hist_r   <= 1'b1;
      phase_r       <= 8'h00;
      sync_r        <= 1'b0;
      rom_latch_r   <= 2'b00;
      running_r     <= 1'b0;
      halted_r      <= 1'b1;
    end else begin
      state_r       <= state_next_s;
      ph_r          <= ph_next_s;
      step_active_r <= step_active_next_s;
      step_hist_r   <= step_req;
      if (state_next_s == RUN) begin
        phase_r     <= phase_onehot(ph_next_s);
        sync_r      <= (ph_next_s == PH_X3);
        rom_latch_r <= rom_latch_decode(ph_next_s);
        running_r   <= 1'b1;
        halted_r    <= 1'b0;
      end else begin
        phase_r     <= 8'h00;
        sync_r      <= 1'b0;
        rom_latch_r <= 2'b00;
        running_r   <= 1'b0;
        halted_r    <= 1'b1;
      end
    end
  end

  assign phase     = phase_r;
  assign sync      = sync_r;
  assign rom_latch = rom_latch_r;
  assign running   = running_r;
  assign halted    = halted_r;

`ifdef CYCLE_SEQUENCER_COUNT_EN
  logic cycle_done_s;

  // A cycle is complete on the edge that leaves X3 while running
  assign cycle_done_s = (state_r == RUN) && (ph_r == PH_X3);

  cycle_counter #(
    .COUNT_W (COUNT_W)
  ) u_cycle_counter (
    .clock (clock),
    .reset (reset),
    .inc   (cycle_done_s),
    .count (cycle_count)
  );
`else
  assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_cycle_sequencer.sv
// Directed self-checking bench for cycle_sequencer (COUNT_W = 4 so the
// counter wrap is reachable). Expected counter values follow the build:
// zero when CYCLE_SEQUENCER_COUNT_EN is undefined.
module tb_cycle_sequencer;

  logic       clock;
  logic       reset;
  logic       halt_req;
  logic       step_req;
  logic [7:0] phase;
  logic       sync;
  logic [1:0] rom_latch;
  logic       running;
  logic       halted;
  logic [3:0] cycle_count;

  int tests;
  int fails;
  int exp_cnt;

  cycle_sequencer #(.COUNT_W(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .halt_req    (halt_req),
    .step_req    (step_req),
    .phase       (phase),
    .sync        (sync),
    .rom_latch   (rom_latch),
    .running     (running),
    .halted      (halted),
    .cycle_count (cycle_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] cnt_exp();
`ifdef CYCLE_SEQUENCER_COUNT_EN
    return 32'(exp_cnt % 16);
`else
    return 32'd0;
`endif
  endfunction

  task automatic chk_run(input string tag, input int p);
    logic [7:0] ph_exp;
    logic [1:0] rl_exp;
    ph_exp = 8'h01 << p;
    rl_exp = (p == 3) ? 2'b10 : ((p == 4) ? 2'b01 : 2'b00);
    chk({tag, ".phase"}, {24'd0, phase}, {24'd0, ph_exp});
    chk({tag, ".sync"}, {31'd0, sync}, {31'd0, (p == 7)});
    chk({tag, ".rom_latch"}, {30'd0, rom_latch}, {30'd0, rl_exp});
    chk({tag, ".running"}, {31'd0, running}, 32'd1);
    chk({tag, ".halted"}, {31'd0, halted}, 32'd0);
  endtask

  task automatic chk_halted(input string tag);
    chk({tag, ".phase"}, {24'd0, phase}, 32'd0);
    chk({tag, ".sync"}, {31'd0, sync}, 32'd0);
    chk({tag, ".rom_latch"}, {30'd0, rom_latch}, 32'd0);
    chk({tag, ".running"}, {31'd0, running}, 32'd0);
    chk({tag, ".halted"}, {31'd0, halted}, 32'd1);
  endtask

  initial begin
    tests    = 0;
    fails    = 0;
    exp_cnt  = 0;
    reset    = 1'b1;
    halt_req = 1'b0;
    step_req = 1'b0;

    // Reset values
    tick();
    tick();
    chk_halted("reset");
    chk("reset.count", {28'd0, cycle_count}, 32'd0);

    // Free run from reset release: A1 one clock later, back-to-back cycles
    reset = 1'b0;
    for (int i = 0; i <= 24; i++) begin
      tick();
      chk_run("run", i % 8);
      exp_cnt = i / 8;
      chk("run.count", {28'd0, cycle_count}, cnt_exp());
    end
    exp_cnt = 3;

    // Halt requested during M1: finish cycle, then park
    for (int p = 1; p <= 3; p++) begin
      tick();
      chk_run("pre_halt", p);
    end
    halt_req = 1'b1;
    for (int p = 4; p <= 7; p++) begin
      tick();
      chk_run("halt_drain", p);
    end
    exp_cnt = 4;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_halted("halt_park");
    end
    chk("halt.count", {28'd0, cycle_count}, cnt_exp());

    // Resume: A1 exactly one clock after halt_req falls
    halt_req = 1'b0;
    tick();
    chk_run("resume", 0);
    halt_req = 1'b1;
    for (int p = 1; p <= 7; p++) begin
      tick();
      chk_run("resume_cyc", p);
    end
    exp_cnt = 5;
    tick();
    chk_halted("rehalt");
    chk("rehalt.count", {28'd0, cycle_count}, cnt_exp());

    // Step held high for 20 clocks: exactly one cycle
    step_req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i < 8) chk_run("step1", i);
      else chk_halted("step1_park");
    end
    exp_cnt = 6;
    chk("step1.count", {28'd0, cycle_count}, cnt_exp());

    // Second edge gives another cycle; toggles during RUN are not queued
    step_req = 1'b0;
    tick();
    chk_halted("step_low");
    step_req = 1'b1;
    for (int p = 0; p <= 7; p++) begin
      tick();
      chk_run("step2", p);
      step_req = (p % 2 == 1);
    end
    exp_cnt = 7;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_halted("step2_park");
    end
    chk("step2.count", {28'd0, cycle_count}, cnt_exp());

    // Reset asserted at X1 abandons the partial cycle
    step_req = 1'b0;
    halt_req = 1'b0;
    for (int p = 0; p <= 5; p++) begin
      tick();
      chk_run("pre_reset", p);
    end
    reset    = 1'b1;
    step_req = 1'b1;
    halt_req = 1'b1;
    tick();
    chk_halted("mid_reset");
    chk("mid_reset.count", {28'd0, cycle_count}, 32'd0);
    exp_cnt = 0;

    // step_req held high through reset must not produce a step
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_halted("step_thru_reset");
    end

    // 17 uninterrupted cycles: 4-bit counter wraps to 1
    halt_req = 1'b0;
    step_req = 1'b0;
    for (int i = 0; i <= 17 * 8; i++) begin
      tick();
      chk_run("wrap", i % 8);
    end
    exp_cnt = 17;
    chk("wrap.count", {28'd0, cycle_count}, cnt_exp());

    // halt_req pulse high at X2, low at X3: no halt
    for (int p = 1; p <= 5; p++) begin
      tick();
      chk_run("pulse_pre", p);
    end
    halt_req = 1'b1;
    tick();
    chk_run("pulse_x2", 6);
    halt_req = 1'b0;
    tick();
    chk_run("pulse_x3", 7);
    tick();
    chk_run("pulse_next", 0);
    exp_cnt = 18;
    chk("pulse.count", {28'd0, cycle_count}, cnt_exp());

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
